// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// pipe_hazard_ctrl_pkg : shared encodings for the pipeline hazard sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_MD_BUSY = 2'b01;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic dx_en;
    logic xm_en;
    logic mw_en;
    logic fd_clr;
    logic dx_clr;
    logic xm_clr;
    logic md_start;
    logic md_timeout;
  } ctl_t;

  // Free-flowing pipeline: every latch advances, nothing is squashed
  localparam ctl_t CTL_FLOW = ctl_t'(10'b11111_000_00);

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// ============================================================================
// pipe_hazard_ctrl_load_use_detect : lw in D/X feeding a source of F/D
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl_load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             dx_is_load,
  input  logic [REG_W-1:0] dx_rd,
  input  logic [REG_W-1:0] fd_rs,
  input  logic [REG_W-1:0] fd_rt,
  input  logic             fd_uses_rt,
  output logic             hazard
);

  // $zero is never a real dependency
  assign hazard = dx_is_load && (dx_rd != ZERO_REG) &&
                  ((dx_rd == fd_rs) || (fd_uses_rt && (dx_rd == fd_rt)));

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall/flush sequencer for the 5-stage pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             dx_is_load,
  input  logic [REG_W-1:0] dx_rd,
  input  logic [REG_W-1:0] fd_rs,
  input  logic [REG_W-1:0] fd_rt,
  input  logic             fd_uses_rt,
  input  logic             dx_is_md,
  input  logic             br_taken,
  input  logic             md_rdy,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             fd_clr,
  output logic             dx_clr,
  output logic             xm_clr,
  output logic             md_start,
  output logic             md_timeout,
  output logic [1:0]       state_out,
  output logic [31:0]      stall_cnt
);

  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(MD_TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             hazard;
  ctl_t             ctl, ctl_out;

  pipe_hazard_ctrl_load_use_detect u_lud (
    .dx_is_load (dx_is_load),
    .dx_rd      (dx_rd),
    .fd_rs      (fd_rs),
    .fd_rt      (fd_rt),
    .fd_uses_rt (fd_uses_rt),
    .hazard     (hazard)
  );

  always_comb begin
    ctl       = CTL_FLOW;
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (dx_is_md) begin
          ctl.md_start = 1'b1;
          ctl.pc_en    = 1'b0;
          ctl.fd_en    = 1'b0;
          ctl.dx_en    = 1'b0;
          ctl.xm_clr   = 1'b1;
          state_d      = ST_MD_BUSY;
          tmo_cnt_d    = TMO_ONE;
        end else if (br_taken) begin
          ctl.fd_clr = 1'b1;
          ctl.dx_clr = 1'b1;
        end else if (hazard) begin
          ctl.pc_en  = 1'b0;
          ctl.fd_en  = 1'b0;
          ctl.dx_clr = 1'b1;
        end
      end
      ST_MD_BUSY: begin
        // A result arriving on the deadline cycle still counts as success
        if (md_rdy) begin
          state_d   = ST_RUN;
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q >= TMO_MAX) begin
          ctl.md_timeout = 1'b1;
          state_d        = ST_RUN;
          tmo_cnt_d      = '0;
        end else begin
          ctl.pc_en  = 1'b0;
          ctl.fd_en  = 1'b0;
          ctl.dx_en  = 1'b0;
          ctl.xm_clr = 1'b1;
          tmo_cnt_d  = tmo_cnt_q + TMO_ONE;
        end
      end
      default: begin
        state_d   = ST_RUN;
        tmo_cnt_d = '0;
      end
    endcase
  end

  assign ctl_out     = clr ? ctl_t'('0) : ctl;
  assign stall_cnt_d = stall_cnt_q + {31'd0, ~ctl.pc_en};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= ST_RUN;
      tmo_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_en      = ctl_out.pc_en;
  assign fd_en      = ctl_out.fd_en;
  assign dx_en      = ctl_out.dx_en;
  assign xm_en      = ctl_out.xm_en;
  assign mw_en      = ctl_out.mw_en;
  assign fd_clr     = ctl_out.fd_clr;
  assign dx_clr     = ctl_out.dx_clr;
  assign xm_clr     = ctl_out.xm_clr;
  assign md_start   = ctl_out.md_start;
  assign md_timeout = ctl_out.md_timeout;
  assign state_out  = state_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl : directed checks of the hazard sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  // {pc,fd,dx,xm,mw}_en, {fd,dx,xm}_clr, md_start, md_timeout
  localparam logic [9:0] C_RST = 10'b00000_000_00;
  localparam logic [9:0] C_ALL = 10'b11111_000_00;
  localparam logic [9:0] C_LU  = 10'b00111_010_00;
  localparam logic [9:0] C_BR  = 10'b11111_110_00;
  localparam logic [9:0] C_MDS = 10'b00011_001_10;
  localparam logic [9:0] C_MDB = 10'b00011_001_00;
  localparam logic [9:0] C_TMO = 10'b11111_000_01;

  logic        clk = 1'b0;
  logic        clr;
  logic        dx_is_load, fd_uses_rt, dx_is_md, br_taken, md_rdy;
  logic [4:0]  dx_rd, fd_rs, fd_rt;
  logic        pc_en, fd_en, dx_en, xm_en, mw_en;
  logic        fd_clr, dx_clr, xm_clr, md_start, md_timeout;
  logic [1:0]  state_out;
  logic [31:0] stall_cnt;
  logic [9:0]  ctl;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_clr, dx_clr, xm_clr, md_start, md_timeout};

  pipe_hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(6)) dut (
    .clk        (clk),
    .clr        (clr),
    .dx_is_load (dx_is_load),
    .dx_rd      (dx_rd),
    .fd_rs      (fd_rs),
    .fd_rt      (fd_rt),
    .fd_uses_rt (fd_uses_rt),
    .dx_is_md   (dx_is_md),
    .br_taken   (br_taken),
    .md_rdy     (md_rdy),
    .pc_en      (pc_en),
    .fd_en      (fd_en),
    .dx_en      (dx_en),
    .xm_en      (xm_en),
    .mw_en      (mw_en),
    .fd_clr     (fd_clr),
    .dx_clr     (dx_clr),
    .xm_clr     (xm_clr),
    .md_start   (md_start),
    .md_timeout (md_timeout),
    .state_out  (state_out),
    .stall_cnt  (stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then let inputs/outputs settle mid-cycle
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    dx_is_load = 1'b0; dx_rd = 5'd0; fd_rs = 5'd0; fd_rt = 5'd0;
    fd_uses_rt = 1'b0; dx_is_md = 1'b0; br_taken = 1'b0; md_rdy = 1'b0;
  endtask

  initial begin
    clr = 1'b1;
    idle_inputs();
    tick(); tick();
    check_eq("rst_state", 32'(state_out), 32'd0);
    check_eq("rst_ctl", 32'(ctl), 32'(C_RST));
    check_eq("rst_stall", stall_cnt, 32'd0);

    clr = 1'b0;
    #2 check_eq("release_ctl", 32'(ctl), 32'(C_ALL));
    tick();

    // load-use on rs
    dx_is_load = 1'b1; dx_rd = 5'd5; fd_rs = 5'd5;
    #2 check_eq("lu_rs_ctl", 32'(ctl), 32'(C_LU));
    tick();
    idle_inputs();
    #2 check_eq("lu_rs_after_ctl", 32'(ctl), 32'(C_ALL));
    check_eq("lu_rs_stall", stall_cnt, 32'd1);

    // load into $zero is not a hazard
    dx_is_load = 1'b1; dx_rd = 5'd0; fd_rs = 5'd0;
    #2 check_eq("lu_zero_ctl", 32'(ctl), 32'(C_ALL));
    tick();
    check_eq("lu_zero_stall", stall_cnt, 32'd1);

    // rt match only counts when F/D reads rt
    dx_rd = 5'd7; fd_rt = 5'd7; fd_rs = 5'd3; fd_uses_rt = 1'b0;
    #2 check_eq("lu_rt_unused", 32'(ctl), 32'(C_ALL));
    fd_uses_rt = 1'b1;
    #2 check_eq("lu_rt_used", 32'(ctl), 32'(C_LU));
    tick();
    idle_inputs();
    check_eq("lu_rt_stall", stall_cnt, 32'd2);

    // taken branch overrides a pending load-use
    br_taken = 1'b1; dx_is_load = 1'b1; dx_rd = 5'd5; fd_rs = 5'd5;
    #2 check_eq("br_ctl", 32'(ctl), 32'(C_BR));
    tick();
    idle_inputs();
    check_eq("br_stall", stall_cnt, 32'd2);

    // stray md_rdy in RUN is ignored
    md_rdy = 1'b1;
    #2 check_eq("rdy_in_run", 32'(ctl), 32'(C_ALL));
    tick();
    md_rdy = 1'b0;

    // mul/div with result after 16 busy cycles; branch/load-use noise ignored
    dx_is_md = 1'b1; br_taken = 1'b1;
    #2 check_eq("md_start_ctl", 32'(ctl), 32'(C_MDS));
    tick();
    dx_is_load = 1'b1; dx_rd = 5'd4; fd_rs = 5'd4;
    for (int i = 1; i <= 16; i++) begin
      #2 check_eq($sformatf("md_busy%0d_ctl", i), 32'(ctl), 32'(C_MDB));
      check_eq($sformatf("md_busy%0d_st", i), 32'(state_out), 32'd1);
      tick();
    end
    md_rdy = 1'b1;
    #2 check_eq("md_rdy_ctl", 32'(ctl), 32'(C_ALL));
    tick();
    idle_inputs();
    check_eq("md_done_state", 32'(state_out), 32'd0);
    check_eq("md_stall", stall_cnt, 32'd19);

    // timeout lands in the 40th busy cycle
    dx_is_md = 1'b1;
    #2 check_eq("tmo_start_ctl", 32'(ctl), 32'(C_MDS));
    tick();
    for (int i = 1; i <= 39; i++) begin
      #2 check_eq($sformatf("tmo_busy%0d_ctl", i), 32'(ctl), 32'(C_MDB));
      tick();
    end
    #2 check_eq("tmo_pulse_ctl", 32'(ctl), 32'(C_TMO));
    check_eq("tmo_pulse_st", 32'(state_out), 32'd1);
    tick();
    idle_inputs();
    check_eq("tmo_after_state", 32'(state_out), 32'd0);
    #2 check_eq("tmo_after_ctl", 32'(ctl), 32'(C_ALL));
    check_eq("tmo_stall", stall_cnt, 32'd59);

    // md_rdy on the deadline cycle suppresses the timeout
    dx_is_md = 1'b1;
    tick();
    for (int i = 1; i <= 39; i++) tick();
    md_rdy = 1'b1;
    #2 check_eq("tmo_rdy_ctl", 32'(ctl), 32'(C_ALL));
    tick();
    idle_inputs();
    check_eq("tmo_rdy_state", 32'(state_out), 32'd0);
    check_eq("tmo_rdy_stall", stall_cnt, 32'd99);

    // back-to-back mul/div, then reset while busy
    dx_is_md = 1'b1;
    tick(); tick();
    check_eq("pre_rst_state", 32'(state_out), 32'd1);
    clr = 1'b1;
    #1 check_eq("midrst_state", 32'(state_out), 32'd0);
    check_eq("midrst_ctl", 32'(ctl), 32'(C_RST));
    check_eq("midrst_stall", stall_cnt, 32'd0);
    tick();
    clr = 1'b0;
    idle_inputs();
    #2 check_eq("post_rst_ctl", 32'(ctl), 32'(C_ALL));
    check_eq("post_rst_state", 32'(state_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
